// File: rtl/if_stage_pkg.sv
// Shared microRISC fetch definitions: widths, NOP, reset PC, step, depth.
// IF_PREFETCH_EN selects the two-deep prefetch; otherwise one deep.
package if_stage_pkg;

  localparam int XLEN = 16;
  localparam logic [XLEN-1:0] NOP_DEF = 16'h0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [XLEN-1:0] INSTR_STEP = 16'd2;

`ifdef IF_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } fetch_tag_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// In-order synchronous FIFO with push, pop, clear and occupancy count.
// Clear wins over a same-cycle push; IF_PREFETCH_EN sets the depth used.
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push &&
                     ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear)
      r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (i_rst || i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push)
        r_wr <= nxt(r_wr);
      if (w_do_pop)
        r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// microRISC instruction fetch: PC, imem handshake, prefetch FIFO, IF/ID reg.
// IF_PREFETCH_EN enables two outstanding fetches; default is one.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            id_valid
);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_epoch;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  logic [CW-1:0]   w_out_cnt;
  logic [CW-1:0]   w_fifo_cnt;
  logic [CW:0]     w_used;
  logic            w_load;
  logic            w_pop;
  logic            w_issue;
  logic            w_rsp;
  logic            w_keep;
  fetch_tag_t      w_tag_in;
  fetch_tag_t      w_tag_head;
  fetch_entry_t    w_ent_in;
  fetch_entry_t    w_head;

  assign w_load = !stall && !flush;
  assign w_pop  = w_load && (w_fifo_cnt != '0);

  // a same-cycle pop frees its slot so 1-cycle memory can stream
  assign w_used = {1'b0, w_out_cnt} + {1'b0, w_fifo_cnt}
                - {{CW{1'b0}}, w_pop};

  assign imem_req  = !rst && !redirect &&
                     (w_used < (CW+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_ready;
  assign w_rsp     = imem_rvalid && (w_out_cnt != '0);

  assign w_tag_in = '{epoch: r_epoch, pc: r_fetch_pc};
  assign w_keep   = w_rsp && (w_tag_head.epoch == r_epoch);
  assign w_ent_in = '{pc: w_tag_head.pc, instr: imem_rdata};

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_tag_t))
  ) u_tag_q (
    .clk     (clk),
    .i_rst   (rst),
    .i_clear (1'b0),
    .i_push  (w_issue),
    .i_data  (w_tag_in),
    .i_pop   (w_rsp),
    .o_data  (w_tag_head),
    .o_count (w_out_cnt)
  );

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .i_rst   (rst),
    .i_clear (redirect),
    .i_push  (w_keep),
    .i_data  (w_ent_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_epoch    <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:1], 1'b0};
      r_epoch    <= ~r_epoch;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + INSTR_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (!stall) begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_instr <= w_head.instr;
        r_pc    <= w_head.pc;
      end else begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
        r_pc    <= '0;
      end
    end
  end

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign id_valid    = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: random memory, stalls, flushes, redirects.
// Define IF_PREFETCH_EN for both bench and RTL to test the two-deep build.
module tb_if_stage;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] RPC = 16'h0000;
`ifdef IF_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        id_valid;

  if_stage #(
    .RESET_PC  (RPC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .id_valid    (id_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_deliv = 0;

  logic [15:0] mq[$];
  logic [31:0] exq[$];
  logic [15:0] next_pc = RPC;

  logic        f_rst = 1'b1;
  logic        f_flush = 1'b0;
  logic        f_stall = 1'b0;
  logic [15:0] last_instr = '0;
  logic [15:0] last_pc = '0;
  logic        last_valid = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: drive at +1, account for handshakes at +4
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic rd, input logic [15:0] rpc,
                      input int rdy, input int rsp);
    @(posedge clk);
    #1;
    rst         = r;
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = ($urandom_range(99) < rdy);
    imem_rvalid = !r && (mq.size() > 0) && ($urandom_range(99) < rsp);
    imem_rdata  = imem_rvalid ? mem_word(mq[0]) : 16'($urandom);
    #3;
    f_rst   = r;
    f_flush = fl;
    f_stall = st;
    if (r) begin
      mq.delete();
      exq.delete();
      next_pc = RPC;
    end else begin
      if (imem_rvalid) void'(mq.pop_front());
      if (imem_req && imem_ready) begin
        check("addr_even", 32'(imem_addr[0]), 32'd0);
        mq.push_back(imem_addr);
        check("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
      end
      if (rd) begin
        check("req_low_on_redirect", 32'(imem_req), 32'd0);
        exq.delete();
        next_pc = rpc & 16'hFFFE;
      end
    end
    while (exq.size() < 8) begin
      exq.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 16'd2;
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (f_rst || f_flush) begin
        check("squash", {15'd0, id_valid, instruction}, {15'd0, 1'b0, NOP});
      end else if (f_stall) begin
        check("stall_hold_pc", {16'd0, pc}, {16'd0, last_pc});
        check("stall_hold_iv", {15'd0, id_valid, instruction},
              {15'd0, last_valid, last_instr});
      end else if (id_valid) begin
        if (exq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL ifid_stream: got %h%h expected none", pc, instruction);
        end else begin
          check("ifid_stream", {pc, instruction}, exq.pop_front());
          n_deliv++;
        end
      end else begin
        check("bubble_nop", {16'd0, instruction}, {16'd0, NOP});
      end
      last_valid = id_valid;
      last_pc    = pc;
      last_instr = instruction;
    end
  end

  initial begin : driver
    int nv;
    repeat (3) step(1, 0, 0, 0, 16'h0, 100, 100);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", 32'(instruction), 32'(NOP));
    check("rst_pc", 32'(pc), 32'd0);

    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 16'h0, 100, 100);
      if (c == 0)
        check("first_req", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, RPC});
      if (c == 1)
        check("second_addr", 32'(imem_addr), 32'(RPC + 16'd2));
      check("valid_rise", 32'(id_valid), 32'(c == 3));
    end

    nv = 0;
    for (int c = 4; c < 12; c++) begin
      step(0, 0, 0, 0, 16'h0, 100, 100);
      nv += int'(id_valid);
    end
    check("throughput", 32'(nv), 32'((DEPTH == 2) ? 8 : 4));

    repeat (3) step(0, 1, 0, 0, 16'h0, 100, 100);
    check("stall_req_low", 32'(imem_req), 32'd0);
    repeat (4) step(0, 0, 0, 0, 16'h0, 100, 100);

    step(0, 0, 1, 1, 16'h0041, 100, 100);
    step(0, 0, 0, 0, 16'h0, 100, 100);
    check("redirect_addr", {15'd0, imem_req, imem_addr},
          {15'd0, 1'b1, 16'h0040});
    repeat (6) step(0, 0, 0, 0, 16'h0, 100, 100);

    repeat (5) step(0, 0, 0, 0, 16'h0, 0, 100);
    check("drain_valid", {15'd0, id_valid, instruction}, {15'd0, 1'b0, NOP});
    repeat (6) step(0, 0, 0, 0, 16'h0, 100, 100);

    step(0, 0, 1, 1, 16'hFFFE, 100, 100);
    step(0, 0, 0, 0, 16'h0, 100, 100);
    check("wrap_first", {15'd0, imem_req, imem_addr},
          {15'd0, 1'b1, 16'hFFFE});
    step(0, 0, 0, 0, 16'h0, 100, 100);
    check("wrap_next", 32'(imem_addr), 32'h0000);
    repeat (6) step(0, 0, 0, 0, 16'h0, 100, 100);

    for (int i = 0; i < 2500; i++) begin
      logic st, fl, rd;
      st = ($urandom_range(99) < 20);
      rd = ($urandom_range(99) < 3);
      fl = rd || ($urandom_range(99) < 5);
      step(0, st, fl, rd, 16'($urandom), 70, 70);
    end
    repeat (12) step(0, 0, 0, 0, 16'h0, 100, 100);

    check("delivered_enough", 32'(n_deliv > 200), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit microRISC pipeline, the producer end of the IF/ID interface whose consumer is the decode stage. It maintains the fetch PC, issues requests to instruction memory over a request/response handshake, buffers returned words in a small in-order prefetch FIFO, and drives the IF/ID pipeline register (instruction, pc, valid) under decode-side stall and flush. On a taken branch or jump it redirects the fetch PC and discards every in-flight and buffered fetch.

## Interface
Parameters:
- RESET_PC, 16'h0000, byte address fetched first after reset
- NOP_INSTR, 16'h0000, encoding driven on instruction when the slot is invalid

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- stall  in  1  hold IF/ID outputs unchanged
- flush  in  1  squash IF/ID slot (insert bubble)
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  16  new fetch address; bit 0 ignored (forced 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch byte address (= fetch_pc)
- imem_ready  in  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  in  1  response valid; responses return strictly in order
- imem_rdata  in  16  response instruction word
- instruction  out  16  IF/ID instruction
- pc  out  16  byte address of instruction
- id_valid  out  1  IF/ID slot holds a real instruction

Clocking is fixed: one clock, clk; reset rst is synchronous and active-high.

## Operation
- State: fetch_pc, outstanding count (0..DEPTH), per-request epoch tags (in-order queue, DEPTH entries), current epoch bit, FIFO of {pc, instr} with DEPTH entries, IF/ID register.
- Issue: imem_req = !rst && !redirect && (outstanding + fifo_count < DEPTH). On accept: fetch_pc += 2 (wraps 16'hFFFE -> 16'h0000), outstanding++, push current epoch to tag queue.
- Response: imem_rvalid pops tag queue, outstanding--. Tag == current epoch -> push {pc of that request, imem_rdata} into FIFO; otherwise dropped silently. Issue and response in same cycle: count unchanged.
- IF/ID update, priority: rst > flush > stall > load. flush: id_valid<=0, instruction<=NOP_INSTR, pc<=0, FIFO head not popped. stall: hold all three. Otherwise: FIFO non-empty -> pop head into register, id_valid<=1; empty -> bubble (id_valid<=0, NOP_INSTR).
- Redirect: fetch_pc<=redirect_pc&16'hFFFE, epoch toggles, FIFO cleared; in-flight responses become stale and are dropped on arrival. Redirect does not itself touch IF/ID; the controller asserts flush alongside. Redirect with stall: redirect still takes effect, IF/ID held.
- Memory is reset together with this block; no response arrives for pre-reset requests.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC after first cycle out of reset, instruction NOP_INSTR, pc 16'h0000, id_valid 0; FIFO empty, outstanding 0, epoch 0.
- First request: cycle after rst deasserts.
- Latency: rvalid in cycle N -> FIFO entry in N+1 -> id_valid/instruction in N+2 (no bypass).
- Redirect in cycle R: imem_req low in R, first request to new target in R+1.
- Steady state with 1-cycle memory and no stall: one instruction per cycle (prefetch enabled).
- FIFO full or credits exhausted: imem_req low until a slot frees; a pop and a response in the same cycle are both honoured.

## Configuration
- IF_PREFETCH_EN defined: DEPTH = 2 (two outstanding requests, two-entry FIFO), full throughput at 1-cycle memory latency.
- Undefined: DEPTH = 1; one outstanding request, single-entry buffer; throughput at most one instruction per two cycles. All other behaviour identical.

## Structure
- Shared defines: XLEN (16), NOP encoding, RESET_PC default, instruction-step constant (2).
- Sub-module if_fetch_fifo: parameterised-depth synchronous FIFO of {pc, instr} with push, pop, clear, count; clear has priority over push.

## Test plan
- Reset, memory always ready, 1-cycle latency: imem_addr 0000, 0002, 0004...; id_valid rises in cycle 3; pc sequence 0000, 0002, 0004 with matching instructions.
- stall held 3 cycles at pc=0004: instruction/pc unchanged, imem_req drops once FIFO+outstanding = DEPTH, no word lost after release.
- redirect to 16'h0041 with flush while two requests in flight: next imem_addr 0040, both stale responses dropped, next id_valid shows pc=0040.
- imem_ready low 5 cycles: id_valid falls after buffer drains, bubbles carry NOP_INSTR, fetch resumes in order.
- fetch_pc at FFFE: next request address 0000.
- Macro undefined: never more than one outstanding request; with 1-cycle memory id_valid toggles every other cycle.
